// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: on a game event, steps a beat index through the hit or score
// effect at a fixed beat rate, then returns to silence (beat 0).
module sfx_sequencer #(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned BEAT_HZ = 8,
  parameter int unsigned LEN0    = 6,
  parameter int unsigned LEN1    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig_hit,
  input  logic       trig_score,
  input  logic       mute,
  output logic [7:0] ibeat_num,
  output logic       sel,
  output logic       busy,
  output logic       done
);

  localparam int unsigned Div = CLK_HZ / BEAT_HZ;

  typedef enum logic [0:0] {StIdle, StPlay} state_e;

  state_e      state_q;
  logic [31:0] timer_q;
  logic [7:0]  beat_q;
  logic        sel_q;
  logic        done_q;

  logic        start;
  logic        tick;
  logic        last_beat;
  logic [31:0] len_m1;

  // Score always (re)starts; hit only starts from idle.
  assign start     = trig_score | (trig_hit & (state_q == StIdle));
  assign tick      = (state_q == StPlay) && (timer_q == Div - 1);
  assign len_m1    = sel_q ? (LEN1 - 1) : (LEN0 - 1);
  assign last_beat = ({24'd0, beat_q} >= len_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      beat_q  <= '0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q <= StPlay;
        sel_q   <= trig_score;
        beat_q  <= '0;
        timer_q <= '0;
      end else if (state_q == StPlay) begin
        if (tick) begin
          timer_q <= '0;
          if (last_beat) begin
            state_q <= StIdle;
            beat_q  <= '0;
            done_q  <= 1'b1;
          end else begin
            beat_q <= beat_q + 8'd1;
          end
        end else begin
          timer_q <= timer_q + 32'd1;
        end
      end
    end
  end

  assign ibeat_num = mute ? 8'd0 : beat_q;
  assign sel       = sel_q;
  assign busy      = (state_q == StPlay);
  assign done      = done_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with DIV = 10 (hit = 6 beats, score = 7 beats).
module tb_sfx_sequencer;

  logic       clk;
  logic       rst;
  logic       trig_hit;
  logic       trig_score;
  logic       mute;
  logic [7:0] ibeat_num;
  logic       sel;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  sfx_sequencer #(
    .CLK_HZ (40),
    .BEAT_HZ(4),
    .LEN0   (6),
    .LEN1   (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trig_hit  (trig_hit),
    .trig_score(trig_score),
    .mute      (mute),
    .ibeat_num (ibeat_num),
    .sel       (sel),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    trig_hit = 1'b0;
    trig_score = 1'b0;
    mute = 1'b0;
    step();
    step();
    checks++;
    if ({ibeat_num, sel, busy, done} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got beat=%0d sel=%0b busy=%0b done=%0b required all 0",
               ibeat_num, sel, busy, done);
    end
    rst = 1'b0;
    for (int j = 0; j < 50; j++) begin
      step();
      checks++;
      if (ibeat_num !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet c%0d: got beat=%0d busy=%0b done=%0b required 0/0/0",
                 j, ibeat_num, busy, done);
      end
    end
  endtask

  task automatic test_hit();
    trig_hit = 1'b1;
    step();
    trig_hit = 1'b0;
    checks++;
    if (sel !== 1'b0 || busy !== 1'b1 || ibeat_num !== 8'd0) begin
      errors++;
      $display("FAIL hit_start: got sel=%0b busy=%0b beat=%0d required 0/1/0",
               sel, busy, ibeat_num);
    end
    for (int j = 1; j <= 61; j++) begin
      step();
      checks++;
      if (ibeat_num !== ((j < 60) ? j / 10 : 0) || busy !== (j < 60) || done !== (j == 60)) begin
        errors++;
        $display("FAIL hit_seq +%0d: got beat=%0d busy=%0b done=%0b required %0d/%0b/%0b",
                 j, ibeat_num, busy, done, (j < 60) ? j / 10 : 0, j < 60, j == 60);
      end
    end
  endtask

  task automatic test_score();
    trig_score = 1'b1;
    step();
    trig_score = 1'b0;
    for (int j = 1; j <= 71; j++) begin
      step();
      checks++;
      if (ibeat_num !== ((j < 70) ? j / 10 : 0) || busy !== (j < 70) || done !== (j == 70)
          || sel !== 1'b1) begin
        errors++;
        $display("FAIL score_seq +%0d: got beat=%0d busy=%0b done=%0b sel=%0b required %0d/%0b/%0b/1",
                 j, ibeat_num, busy, done, sel, (j < 70) ? j / 10 : 0, j < 70, j == 70);
      end
    end
  endtask

  task automatic test_preempt();
    trig_hit = 1'b1;
    step();
    trig_hit = 1'b0;
    for (int j = 1; j <= 25; j++) step();
    trig_score = 1'b1;
    step();
    trig_score = 1'b0;
    checks++;
    if (sel !== 1'b1 || busy !== 1'b1 || ibeat_num !== 8'd0) begin
      errors++;
      $display("FAIL preempt_start: got sel=%0b busy=%0b beat=%0d required 1/1/0",
               sel, busy, ibeat_num);
    end
    // The hit effect would have ended 34 cycles in; no done may appear there.
    for (int j = 1; j <= 71; j++) begin
      step();
      checks++;
      if (ibeat_num !== ((j < 70) ? j / 10 : 0) || done !== (j == 70)) begin
        errors++;
        $display("FAIL preempt_seq +%0d: got beat=%0d done=%0b required %0d/%0b",
                 j, ibeat_num, done, (j < 70) ? j / 10 : 0, j == 70);
      end
    end
  endtask

  task automatic test_simultaneous();
    trig_hit = 1'b1;
    trig_score = 1'b1;
    step();
    trig_hit = 1'b0;
    trig_score = 1'b0;
    checks++;
    if (sel !== 1'b1 || busy !== 1'b1 || ibeat_num !== 8'd0) begin
      errors++;
      $display("FAIL both_trig: got sel=%0b busy=%0b beat=%0d required 1/1/0",
               sel, busy, ibeat_num);
    end
    // A hit pulse mid-effect must not disturb the score sequence.
    for (int j = 1; j <= 70; j++) begin
      if (j == 16) trig_hit = 1'b1;
      step();
      trig_hit = 1'b0;
      checks++;
      if (ibeat_num !== ((j < 70) ? j / 10 : 0) || sel !== 1'b1 || done !== (j == 70)) begin
        errors++;
        $display("FAIL hit_ignored +%0d: got beat=%0d sel=%0b done=%0b required %0d/1/%0b",
                 j, ibeat_num, sel, done, (j < 70) ? j / 10 : 0, j == 70);
      end
    end
  endtask

  task automatic test_finish_tick_trigger();
    trig_hit = 1'b1;
    step();
    trig_hit = 1'b0;
    for (int j = 1; j <= 59; j++) step();
    trig_score = 1'b1;
    step();
    trig_score = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || sel !== 1'b1 || ibeat_num !== 8'd0) begin
      errors++;
      $display("FAIL finish_restart: got done=%0b busy=%0b sel=%0b beat=%0d required 0/1/1/0",
               done, busy, sel, ibeat_num);
    end
    for (int j = 1; j <= 70; j++) begin
      step();
      checks++;
      if (ibeat_num !== ((j < 70) ? j / 10 : 0) || done !== (j == 70)) begin
        errors++;
        $display("FAIL finish_seq +%0d: got beat=%0d done=%0b required %0d/%0b",
                 j, ibeat_num, done, (j < 70) ? j / 10 : 0, j == 70);
      end
    end
  endtask

  task automatic test_mute();
    int exp_beat;
    trig_hit = 1'b1;
    step();
    trig_hit = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      step();
      mute = (j >= 20 && j < 40);
      #1;
      exp_beat = (mute || j >= 60) ? 0 : j / 10;
      checks++;
      if (ibeat_num !== exp_beat || busy !== (j < 60) || done !== (j == 60)) begin
        errors++;
        $display("FAIL mute +%0d: got beat=%0d busy=%0b done=%0b required %0d/%0b/%0b",
                 j, ibeat_num, busy, done, exp_beat, j < 60, j == 60);
      end
    end
    mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    trig_score = 1'b1;
    step();
    trig_score = 1'b0;
    for (int j = 1; j <= 35; j++) step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ibeat_num, sel, busy, done} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got beat=%0d sel=%0b busy=%0b done=%0b required all 0",
               ibeat_num, sel, busy, done);
    end
    step();
    step();
    rst = 1'b0;
    for (int j = 0; j < 80; j++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || ibeat_num !== 8'd0) begin
        errors++;
        $display("FAIL reset_no_done c%0d: got done=%0b busy=%0b beat=%0d required 0/0/0",
                 j, done, busy, ibeat_num);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_score();
    test_preempt();
    test_simultaneous();
    test_finish_tick_trigger();
    test_mute();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
